// File: rtl/brick_hit_ctrl.sv
// Once per frame, at the first blanking line, scans the ten bricks against the latched ball box
// and issues at most one erase/hit pulse, plus a bounce direction and score update.
module brick_hit_ctrl #(
  parameter int BALL_SIZE     = 7,
  parameter int HITS_TO_CLEAR = 3,
  parameter int SCAN_LINE     = 480
) (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       active_write_enable,
  output logic [5:0] erase_pos,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic [7:0] score,
  output logic       all_cleared,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for the start-of-blanking trigger
  // SCAN  | testing one brick per cycle, index 0..9
  // ERASE | one-cycle hit pulse to the renderer
  typedef enum logic [1:0] {IDLE, SCAN, ERASE} state_t;

  localparam logic [1:0] HTC        = 2'(HITS_TO_CLEAR);
  localparam logic [9:0] SCAN_V     = 10'(SCAN_LINE);
  localparam logic [10:0] BALL_EXT  = 11'(BALL_SIZE);
  localparam logic [10:0] BRICK_W   = 11'd80;
  localparam logic [10:0] BRICK_H   = 11'd30;
  localparam logic [3:0] LAST_IDX   = 4'd9;

  state_t          r_state;
  logic [3:0]      r_idx;
  logic            r_found;
  logic [3:0]      r_hit_idx;
  logic [9:0]      r_bx;
  logic [9:0]      r_by;
  logic [9:0][1:0] r_cnt;

  logic [10:0] w_cur_bx;
  logic [10:0] w_cur_by;
  logic [10:0] w_ball_x11;
  logic [10:0] w_ball_y11;
  logic [10:0] w_ball_xe;
  logic [10:0] w_ball_ye;
  logic [1:0]  w_cur_cnt;
  logic        w_overlap;
  logic        w_hit_now;
  logic [3:0]  w_sel_idx;
  logic        w_sel_found;
  logic [10:0] w_sel_bx;
  logic [10:0] w_cx;
  logic        w_centre;
  logic [1:0]  w_sel_cnt;
  logic [1:0]  w_new_cnt;
  logic        w_destroy;
  logic [7:0]  w_score_next;
  logic        w_trigger;

  function automatic logic [10:0] brick_x(input logic [3:0] i);
    logic [10:0] v;
    case (i)
      4'd0, 4'd5: v = 11'd40;
      4'd1, 4'd6: v = 11'd160;
      4'd2, 4'd7: v = 11'd280;
      4'd3, 4'd8: v = 11'd400;
      4'd4, 4'd9: v = 11'd520;
      default:    v = 11'd0;
    endcase
    return v;
  endfunction

  function automatic logic [10:0] brick_y(input logic [3:0] i);
    return (i < 4'd5) ? 11'd40 : 11'd90;
  endfunction

  assign w_trigger  = (hor_count == 10'd0) && (ver_count == SCAN_V);

  // All geometry is evaluated at 11 bits so ball_x + BALL_SIZE never wraps.
  assign w_ball_x11 = {1'b0, r_bx};
  assign w_ball_y11 = {1'b0, r_by};
  assign w_ball_xe  = w_ball_x11 + BALL_EXT;
  assign w_ball_ye  = w_ball_y11 + BALL_EXT;
  assign w_cur_bx   = brick_x(r_idx);
  assign w_cur_by   = brick_y(r_idx);

  always_comb begin
    w_cur_cnt = 2'd0;
    w_sel_cnt = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_idx == 4'(i))     w_cur_cnt = r_cnt[i];
      if (w_sel_idx == 4'(i)) w_sel_cnt = r_cnt[i];
    end
  end

  assign w_overlap = (w_ball_x11 <= w_cur_bx + BRICK_W) && (w_ball_xe >= w_cur_bx) &&
                     (w_ball_y11 <= w_cur_by + BRICK_H) && (w_ball_ye >= w_cur_by);
  assign w_hit_now = w_overlap && (w_cur_cnt != HTC);

  // On the last scan cycle the brick being tested may itself be the first hit.
  assign w_sel_idx    = r_found ? r_hit_idx : r_idx;
  assign w_sel_found  = r_found || w_hit_now;
  assign w_sel_bx     = brick_x(w_sel_idx);
  assign w_cx         = w_ball_x11 + 11'd3;
  assign w_centre     = (w_cx >= w_sel_bx) && (w_cx <= w_sel_bx + BRICK_W);
  assign w_new_cnt    = w_sel_cnt + 2'd1;
  assign w_destroy    = (w_new_cnt == HTC);
  assign w_score_next = score + 8'd1;

  always_ff @(posedge CLK_25MH or negedge reset) begin
    if (!reset) begin
      r_state             <= IDLE;
      r_idx               <= 4'd0;
      r_found             <= 1'b0;
      r_hit_idx           <= 4'd0;
      r_bx                <= 10'd0;
      r_by                <= 10'd0;
      r_cnt               <= '0;
      active_write_enable <= 1'b0;
      erase_pos           <= 6'd0;
      bounce_x            <= 1'b0;
      bounce_y            <= 1'b0;
      score               <= 8'd0;
      all_cleared         <= 1'b0;
      busy                <= 1'b0;
    end else begin
      active_write_enable <= 1'b0;
      bounce_x            <= 1'b0;
      bounce_y            <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state   <= SCAN;
            r_idx     <= 4'd0;
            r_found   <= 1'b0;
            r_hit_idx <= 4'd0;
            r_bx      <= ball_x;
            r_by      <= ball_y;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (w_hit_now && !r_found) begin
            r_found   <= 1'b1;
            r_hit_idx <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            if (w_sel_found) begin
              r_state             <= ERASE;
              active_write_enable <= 1'b1;
              erase_pos           <= {2'b00, w_sel_idx};
              bounce_y            <= w_centre;
              bounce_x            <= !w_centre;
              for (int i = 0; i < 10; i++) begin
                if (w_sel_idx == 4'(i)) r_cnt[i] <= w_new_cnt;
              end
              if (w_destroy) begin
                score <= w_score_next;
                if (w_score_next == 8'd10) all_cleared <= 1'b1;
              end
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ERASE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brick_hit_ctrl.sv
// Directed bench for brick_hit_ctrl: drives scan triggers directly and checks pulse timing,
// brick index, bounce side, score and cleared status against hand-computed values.
module tb_brick_hit_ctrl;

  logic       CLK_25MH = 1'b0;
  logic       reset    = 1'b0;
  logic [9:0] hor_count = 10'd5;
  logic [9:0] ver_count = 10'd0;
  logic [9:0] ball_x = 10'd300;
  logic [9:0] ball_y = 10'd300;
  logic       active_write_enable;
  logic [5:0] erase_pos;
  logic       bounce_x;
  logic       bounce_y;
  logic [7:0] score;
  logic       all_cleared;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  brick_hit_ctrl dut (
    .CLK_25MH           (CLK_25MH),
    .reset              (reset),
    .hor_count          (hor_count),
    .ver_count          (ver_count),
    .ball_x             (ball_x),
    .ball_y             (ball_y),
    .active_write_enable(active_write_enable),
    .erase_pos          (erase_pos),
    .bounce_x           (bounce_x),
    .bounce_y           (bounce_y),
    .score              (score),
    .all_cleared        (all_cleared),
    .busy               (busy)
  );

  always #20 CLK_25MH = ~CLK_25MH;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: trigger at cycle T, observe cycles T+1..T+14. The ball is moved away after the
  // trigger cycle to confirm the scan uses the latched position.
  task automatic frame(input string tag, input int x, input int y, input int exp_hit,
                       input int exp_pos, input int exp_by);
    int pulses, pcyc, pos, by_v, bx_v, bcnt, busyc;
    pulses = 0; pcyc = -1; pos = -1; by_v = -1; bx_v = -1; bcnt = 0; busyc = 0;
    ball_x = 10'(x);
    ball_y = 10'(y);
    @(negedge CLK_25MH);
    hor_count = 10'd0;
    ver_count = 10'd480;
    for (int k = 1; k <= 14; k++) begin
      @(posedge CLK_25MH);
      #1;
      if (k == 1) begin
        hor_count = 10'd5;
        ver_count = 10'd0;
        ball_x    = 10'd600;
        ball_y    = 10'd5;
      end
      if (active_write_enable) begin
        pulses++;
        pcyc = k;
        pos  = int'(erase_pos);
        by_v = int'(bounce_y);
        bx_v = int'(bounce_x);
      end
      if (bounce_x || bounce_y) bcnt++;
      if (busy) busyc++;
    end
    chk({tag, "_pulses"}, pulses, exp_hit);
    chk({tag, "_bounces"}, bcnt, exp_hit);
    chk({tag, "_busy_cycles"}, busyc, 10 + exp_hit);
    if (exp_hit != 0) begin
      chk({tag, "_pulse_cycle"}, pcyc, 11);
      chk({tag, "_erase_pos"}, pos, exp_pos);
      chk({tag, "_bounce_y"}, by_v, exp_by);
      chk({tag, "_bounce_x"}, bx_v, 1 - exp_by);
    end
  endtask

  initial begin
    int pulses;
    int bx, by;
    // reset values
    #30;
    chk("rst_awe", int'(active_write_enable), 0);
    chk("rst_pos", int'(erase_pos), 0);
    chk("rst_bx", int'(bounce_x), 0);
    chk("rst_by", int'(bounce_y), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_cleared", int'(all_cleared), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge CLK_25MH);
    reset = 1'b1;
    repeat (3) @(negedge CLK_25MH);
    chk("post_rst_busy", int'(busy), 0);

    frame("miss_a", 300, 300, 0, 0, 0);
    frame("miss_b", 300, 300, 0, 0, 0);
    chk("miss_score", int'(score), 0);

    // boundaries on brick 0 (x 40..120, y 40..70) and side hit on brick 5
    frame("edge_113", 113, 50, 1, 0, 1);
    frame("edge_121", 121, 50, 0, 0, 0);
    frame("edge_120_71", 120, 71, 0, 0, 0);
    frame("side_35_95", 35, 95, 1, 5, 0);
    chk("edge_score", int'(score), 0);

    // reset in the middle of a scan
    ball_x = 10'd60;
    ball_y = 10'd50;
    @(negedge CLK_25MH);
    hor_count = 10'd0;
    ver_count = 10'd480;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK_25MH);
      #1;
      if (k == 1) begin
        hor_count = 10'd5;
        ver_count = 10'd0;
      end
    end
    chk("midrst_busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_awe", int'(active_write_enable), 0);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK_25MH);
      #1;
      if (k == 2) reset = 1'b1;
      if (active_write_enable) pulses++;
    end
    chk("midrst_pulses", pulses, 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_busy_after", int'(busy), 0);

    // centre hits on brick 0; counts were cleared by the reset above
    frame("centre1", 60, 50, 1, 0, 1);
    chk("centre1_score", int'(score), 0);
    frame("centre2", 60, 50, 1, 0, 1);
    chk("centre2_score", int'(score), 0);
    frame("centre3", 60, 50, 1, 0, 1);
    chk("centre3_score", int'(score), 1);
    frame("centre4", 60, 50, 0, 0, 0);
    chk("centre4_score", int'(score), 1);

    // clear the remaining bricks, three hits each
    for (int i = 1; i < 10; i++) begin
      bx = (i < 5) ? 40 + 120 * i : 40 + 120 * (i - 5);
      by = (i < 5) ? 40 : 90;
      for (int h = 0; h < 3; h++)
        frame($sformatf("clear_b%0d_h%0d", i, h), bx + 20, by + 10, 1, i, 1);
      chk($sformatf("clear_b%0d_score", i), int'(score), i + 1);
      chk($sformatf("clear_b%0d_cleared", i), int'(all_cleared), (i == 9) ? 1 : 0);
    end

    frame("after_clear_a", 60, 50, 0, 0, 0);
    frame("after_clear_b", 580, 100, 0, 0, 0);
    chk("final_score", int'(score), 10);
    chk("final_cleared", int'(all_cleared), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/brick_hit_ctrl.md
Name: brick_hit_ctrl

Overview:
- Producer side of the block-erase interface (`active_write_enable`, `erase_pos`) consumed by the VGA renderer.
- Once per frame, at the start of vertical blanking, it scans the 10 bricks against the ball box and issues at most one erase (hit) command.
- Keeps its own mirror of per-brick hit counts, so destroyed bricks never collide again.
- Reports bounce direction, score and cleared status to the ball-motion logic.

Parameters:
- BALL_SIZE, 7, ball box spans [x, x+BALL_SIZE] and [y, y+BALL_SIZE], inclusive.
- HITS_TO_CLEAR, 3, hits after which a brick is destroyed. Matches the renderer hiding a brick at count 2'b11.
- SCAN_LINE, 480, value of ver_count that triggers the scan (first blanking line).

Ports:
- CLK_25MH  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-low. Top level drives the renderer's active-high reset from ~reset.
- hor_count  in  10  pixel counter from VGA.
- ver_count  in  10  line counter from VGA.
- ball_x  in  10  ball top-left x.
- ball_y  in  10  ball top-left y.
- active_write_enable  out  1  one-cycle erase/hit pulse to VGA.
- erase_pos  out  6  brick index 0..9, valid while active_write_enable=1.
- bounce_x  out  1  one-cycle pulse: reverse horizontal velocity.
- bounce_y  out  1  one-cycle pulse: reverse vertical velocity.
- score  out  8  number of destroyed bricks.
- all_cleared  out  1  level, 1 when all 10 bricks are destroyed.
- busy  out  1  1 while not in IDLE.

Behaviour:
- Reset values (asynchronous, reset=0):
  - state=IDLE.
  - All 10 hit counters = 0.
  - active_write_enable=0, erase_pos=0, bounce_x=0, bounce_y=0.
  - score=0, all_cleared=0, busy=0.
- Brick geometry, fixed, all bounds inclusive:
  - i<5: bx=40+120*i, by=40.
  - i>=5: bx=40+120*(i-5), by=90.
  - Width 80 (bx..bx+80), height 30 (by..by+30).
- Overlap test: ball_x<=bx+80 AND ball_x+BALL_SIZE>=bx AND ball_y<=by+30 AND ball_y+BALL_SIZE>=by.
  - All sums computed at 11 bits; no 10-bit wrap allowed.
- Trigger: hor_count==0 AND ver_count==SCAN_LINE sampled in IDLE.
  - Triggers outside IDLE are ignored.
- ball_x and ball_y are latched on the trigger cycle. Later ball movement does not affect the scan.
- FSM states: IDLE, SCAN, ERASE.
  - IDLE -> SCAN on trigger; index=0.
  - SCAN: one brick per cycle, index 0..9.
    - Bricks with count==HITS_TO_CLEAR are skipped.
    - The first overlapping brick (lowest index) is recorded; later overlaps are ignored this frame.
    - After index 9: go to ERASE if a hit was recorded, else IDLE.
  - ERASE: one cycle, then IDLE. During this cycle (registered outputs):
    - active_write_enable=1, erase_pos=recorded index.
    - Exactly one of bounce_x / bounce_y is 1.
    - The mirror count for that brick increments.
    - If the new count == HITS_TO_CLEAR, score increments.
- Latency: trigger at cycle T → SCAN occupies T+1..T+10 → ERASE pulse at T+11 → IDLE at T+12.
- Bounce side: ball centre cx=ball_x+3.
  - bx<=cx<=bx+80 → bounce_y.
  - Otherwise → bounce_x.
- all_cleared is 1 when score==10. It is sticky until reset.
  - Scans still run afterwards but find no hit.
- Reset asserted mid-scan or during ERASE: immediate return to IDLE; no pulse is emitted.
- Deasserting reset has no effect until the next trigger.
- Mirror-count consistency: active_write_enable is pulsed on every hit, including non-destroying ones. The renderer's counter therefore tracks this block's counter exactly.

Test Plan:
- Reset check: reset=0 then release, run 2 frames, ball at (300,300) → no pulses, score=0, busy high for exactly 10 cycles per frame.
- Centre hit: ball (60,50) → at T+11, active_write_enable=1, erase_pos=0, bounce_y=1 for exactly one cycle.
  - Repeat for 3 frames → score=1.
  - 4th frame → no pulse (brick 0 skipped).
- Edge boundaries: ball (113,50) → hit on brick 0 with bounce_y (cx=116).
  - Ball (121,50) → no hit.
  - Ball (120,71) → no hit (y+7=78 ≥ 40 but 71 > 70).
- Side hit: ball (35,95) → erase_pos=5, bounce_x=1 (cx=38 < 40).
- Reset mid-op: assert reset at T+5 → no active_write_enable, score unchanged at 0, busy=0 immediately.
- Full clear: place the ball over each brick for 3 frames each (30 hits) → score=10, all_cleared=1, and subsequent frames produce no pulses.
